proximity_reg_master: RTL and testbench

- Bus initiator for the proximity sensor SoC memory-mapped register interface.
- Accepts host commands (read/write, address, data) through a small command FIFO.
- Issues one single-cycle reg_read/reg_write strobe per command and waits for the responder's reg_ready, with a timeout.
- Returns rdata/error/timeout on a valid/ready response channel.
- Sits between the host-side control path (boot sequencer or debug bridge) and the configuration register file.

---
 rtl/proximity_sensor_pkg.sv | 27 ++
 rtl/proximity_cmd_fifo.sv | 54 +++++
 rtl/proximity_reg_master.sv | 189 ++++++++++++++++++
 tb/tb_proximity_reg_master.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/proximity_sensor_pkg.sv
// Shared types and constants for the proximity sensor register path:
// register-master FSM states, register address map and the invalid-read pattern.
package proximity_sensor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } reg_master_state_t;

  // Byte addresses of the configuration register file
  localparam logic [7:0] ADDR_CONTROL       = 8'h00;
  localparam logic [7:0] ADDR_FILTER_CFG    = 8'h04;
  localparam logic [7:0] ADDR_THRESH_CFG    = 8'h08;
  localparam logic [7:0] ADDR_LED_CFG       = 8'h0C;
  localparam logic [7:0] ADDR_INT_CFG       = 8'h10;
  localparam logic [7:0] ADDR_INT_STATUS    = 8'h14;
  localparam logic [7:0] ADDR_SAMPLE_PERIOD = 8'h18;
  localparam logic [7:0] ADDR_STATUS        = 8'h1C;
  localparam logic [7:0] ADDR_LOCK          = 8'h20;
  localparam logic [7:0] ADDR_RAW_DATA      = 8'h24;
  localparam logic [7:0] ADDR_FILTERED_DATA = 8'h28;

  localparam logic [31:0] INVALID_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/proximity_cmd_fifo.sv
// First-word-fall-through command FIFO; head entry is visible on o_dout
// whenever o_empty is low. Push when full and pop when empty are ignored.
module proximity_cmd_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed behind r_count
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/proximity_reg_master.sv
// Register-bus initiator: queues host commands, issues one strobe per command,
// waits for reg_ready with a timeout and returns the result on a valid/ready channel.
module proximity_reg_master
  import proximity_sensor_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  output logic                  reg_write,
  output logic                  reg_read,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  reg_ready,
  input  logic                  reg_error,
  output logic                  busy,
  output logic [7:0]            err_count
);

  localparam int FW = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic                  w_full, w_empty, w_push, w_pop;
  logic [FW-1:0]         w_fifo_din, w_fifo_dout;
  logic                  w_head_write;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_wdata;

  reg_master_state_t     r_state, w_state_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic                  r_rsp_error, w_rsp_error_nxt;
  logic                  r_rsp_timeout, w_rsp_timeout_nxt;
  logic                  r_reg_write, w_reg_write_nxt;
  logic                  r_reg_read, w_reg_read_nxt;
  logic [ADDR_WIDTH-1:0] r_reg_addr, w_reg_addr_nxt;
  logic [DATA_WIDTH-1:0] r_reg_wdata, w_reg_wdata_nxt;
  logic                  r_cmd_write, w_cmd_write_nxt;
  logic [TW-1:0]         r_tmo_cnt, w_tmo_cnt_nxt;
  logic [7:0]            r_err_count;

  assign w_push     = cmd_valid && !w_full;
  assign w_fifo_din = {cmd_write, cmd_addr, cmd_wdata};
  assign {w_head_write, w_head_addr, w_head_wdata} = w_fifo_dout;

  proximity_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_din   (w_fifo_din),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_pop             = 1'b0;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_error_nxt   = r_rsp_error;
    w_rsp_timeout_nxt = r_rsp_timeout;
    w_reg_write_nxt   = 1'b0;
    w_reg_read_nxt    = 1'b0;
    w_reg_addr_nxt    = r_reg_addr;
    w_reg_wdata_nxt   = r_reg_wdata;
    w_cmd_write_nxt   = r_cmd_write;
    w_tmo_cnt_nxt     = r_tmo_cnt;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop           = 1'b1;
          w_reg_addr_nxt  = w_head_addr;
          w_reg_wdata_nxt = w_head_wdata;
          w_cmd_write_nxt = w_head_write;
          // Misaligned accesses never reach the responder
          if (w_head_addr[1:0] != 2'b00) begin
            w_state_nxt       = RESP;
            w_rsp_valid_nxt   = 1'b1;
            w_rsp_rdata_nxt   = '0;
            w_rsp_error_nxt   = 1'b1;
            w_rsp_timeout_nxt = 1'b0;
          end else begin
            w_state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        w_reg_write_nxt = r_cmd_write;
        w_reg_read_nxt  = !r_cmd_write;
        w_tmo_cnt_nxt   = '0;
        w_state_nxt     = WAIT;
      end
      WAIT: begin
        // A ready on the terminal-count cycle still yields a normal response
        if (reg_ready) begin
          w_state_nxt       = RESP;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_rdata_nxt   = reg_rdata;
          w_rsp_error_nxt   = reg_error;
          w_rsp_timeout_nxt = 1'b0;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_state_nxt       = RESP;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_rdata_nxt   = '0;
          w_rsp_error_nxt   = 1'b1;
          w_rsp_timeout_nxt = 1'b1;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + TW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_error   <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_reg_write   <= 1'b0;
      r_reg_read    <= 1'b0;
      r_reg_addr    <= '0;
      r_reg_wdata   <= '0;
      r_cmd_write   <= 1'b0;
      r_tmo_cnt     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_error   <= w_rsp_error_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
      r_reg_write   <= w_reg_write_nxt;
      r_reg_read    <= w_reg_read_nxt;
      r_reg_addr    <= w_reg_addr_nxt;
      r_reg_wdata   <= w_reg_wdata_nxt;
      r_cmd_write   <= w_cmd_write_nxt;
      r_tmo_cnt     <= w_tmo_cnt_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_err_count <= '0;
    end else if (r_rsp_valid && rsp_ready && r_rsp_error && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign cmd_ready   = !w_full;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_error   = r_rsp_error;
  assign rsp_timeout = r_rsp_timeout;
  assign reg_write   = r_reg_write;
  assign reg_read    = r_reg_read;
  assign reg_addr    = r_reg_addr;
  assign reg_wdata   = r_reg_wdata;
  assign busy        = (r_state != IDLE) || !w_empty;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_proximity_reg_master.sv
// Directed bench for proximity_reg_master with a small register-file responder
// model that can be switched to a never-ready stub.
module tb_proximity_reg_master;
  import proximity_sensor_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [5:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        reg_write;
  logic        reg_read;
  logic [5:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        reg_ready;
  logic        reg_error;
  logic        busy;
  logic [7:0]  err_count;

  bit          stub_mode = 1'b0;
  int          cyc = 0, n_rd = 0, n_wr = 0, n_both = 0;
  int          n_checks = 0, n_fail = 0;
  logic [31:0] m_ctrl, m_filt, m_thr, m_lock;

  proximity_reg_master dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .reg_write(reg_write), .reg_read(reg_read), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ready(reg_ready),
    .reg_error(reg_error), .busy(busy), .err_count(err_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc++;
    if (reg_read) n_rd++;
    if (reg_write) n_wr++;
    if (reg_read && reg_write) n_both++;
  end

  // Responder: registered ready one cycle after the strobe; THRESH locked by LOCK[0]
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_ctrl <= 32'h0; m_filt <= 32'h8; m_thr <= 32'h100; m_lock <= 32'h0;
      reg_ready <= 1'b0; reg_error <= 1'b0; reg_rdata <= 32'h0;
    end else begin
      reg_ready <= 1'b0; reg_error <= 1'b0; reg_rdata <= 32'h0;
      if ((reg_read || reg_write) && !stub_mode) begin
        reg_ready <= 1'b1;
        if ({2'b00, reg_addr} > ADDR_FILTERED_DATA) begin
          reg_error <= 1'b1;
          if (reg_read) reg_rdata <= INVALID_RDATA;
        end else if (reg_write) begin
          case ({2'b00, reg_addr})
            ADDR_CONTROL:    m_ctrl <= reg_wdata;
            ADDR_FILTER_CFG: m_filt <= reg_wdata;
            ADDR_THRESH_CFG: if (m_lock[0]) reg_error <= 1'b1; else m_thr <= reg_wdata;
            ADDR_LOCK:       m_lock <= reg_wdata;
            default: ;
          endcase
        end else begin
          case ({2'b00, reg_addr})
            ADDR_CONTROL:    reg_rdata <= m_ctrl;
            ADDR_FILTER_CFG: reg_rdata <= m_filt;
            ADDR_THRESH_CFG: reg_rdata <= m_thr;
            ADDR_LOCK:       reg_rdata <= m_lock;
            default:         reg_rdata <= 32'h0;
          endcase
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Push one command, wait for its response; latency counted from the push edge
  task automatic do_cmd(input bit wr, input logic [5:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output logic tm,
                        output int lat);
    int t0, n;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    t0 = cyc;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_val("rsp_seen", {31'b0, rsp_valid}, 32'd1);
    rd = rsp_rdata; er = rsp_error; tm = rsp_timeout; lat = cyc - t0;
  endtask

  logic [31:0] rd;
  logic        er, tm;
  int          lat, rd0, wr0;

  logic [5:0]  bp_addr [6] = '{6'h00, 6'h04, 6'h08, 6'h20, 6'h00, 6'h00};
  logic        bp_wr   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] bp_wd   [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h7, 32'h0};
  logic [31:0] bp_exp  [6] = '{32'h3, 32'h8, 32'h100, 32'h1, 32'h0, 32'h7};

  initial begin
    int idx, got, acc_at_full;
    bit full_seen, acc_next, any_err, saw_rsp;

    // Reset values
    #12;
    check_val("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check_val("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_val("rst_strobes", {30'b0, reg_read, reg_write}, 32'd0);
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_err_count", {24'b0, err_count}, 32'd0);
    check_val("rst_rdata", rsp_rdata, 32'd0);
    @(negedge clock); reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Read FILTER_CFG: one read pulse, four-cycle latency
    rd0 = n_rd; wr0 = n_wr;
    do_cmd(1'b0, 6'h04, 32'h0, rd, er, tm, lat);
    check_val("rd04_data", rd, 32'h8);
    check_val("rd04_err", {31'b0, er}, 32'd0);
    check_val("rd04_tmo", {31'b0, tm}, 32'd0);
    check_val("rd04_latency", lat, 32'd4);
    check_val("rd04_read_pulses", n_rd - rd0, 32'd1);
    check_val("rd04_write_pulses", n_wr - wr0, 32'd0);
    check_val("rd04_busy", {31'b0, busy}, 32'd1);

    // Write CONTROL then read it back
    wr0 = n_wr;
    do_cmd(1'b1, 6'h00, 32'h3, rd, er, tm, lat);
    check_val("wr00_err", {31'b0, er}, 32'd0);
    check_val("wr00_write_pulses", n_wr - wr0, 32'd1);
    do_cmd(1'b0, 6'h00, 32'h0, rd, er, tm, lat);
    check_val("rd00_data", rd, 32'h3);
    check_val("rd00_err", {31'b0, er}, 32'd0);

    // Lock, then a write to THRESH_CFG is refused
    do_cmd(1'b1, 6'h20, 32'h1, rd, er, tm, lat);
    check_val("wr20_err", {31'b0, er}, 32'd0);
    do_cmd(1'b1, 6'h08, 32'h55, rd, er, tm, lat);
    check_val("wr08_locked_err", {31'b0, er}, 32'd1);
    do_cmd(1'b0, 6'h08, 32'h0, rd, er, tm, lat);
    check_val("rd08_data", rd, 32'h100);
    check_val("rd08_err", {31'b0, er}, 32'd0);
    @(negedge clock);
    check_val("err_count_1", {24'b0, err_count}, 32'd1);

    // Unmapped address
    do_cmd(1'b0, 6'h30, 32'h0, rd, er, tm, lat);
    check_val("rd30_data", rd, INVALID_RDATA);
    check_val("rd30_err", {31'b0, er}, 32'd1);
    check_val("rd30_tmo", {31'b0, tm}, 32'd0);

    // Never-ready responder: timeout after 16 WAIT cycles
    stub_mode = 1'b1;
    do_cmd(1'b0, 6'h04, 32'h0, rd, er, tm, lat);
    check_val("tmo_flag", {31'b0, tm}, 32'd1);
    check_val("tmo_err", {31'b0, er}, 32'd1);
    check_val("tmo_data", rd, 32'h0);
    check_val("tmo_latency", lat, 32'd18);

    // Misaligned: immediate error, no strobe
    rd0 = n_rd;
    do_cmd(1'b0, 6'h05, 32'h0, rd, er, tm, lat);
    check_val("mis_err", {31'b0, er}, 32'd1);
    check_val("mis_tmo", {31'b0, tm}, 32'd0);
    check_val("mis_data", rd, 32'h0);
    check_val("mis_latency", lat, 32'd1);
    check_val("mis_no_strobe", n_rd - rd0, 32'd0);
    @(negedge clock);
    check_val("err_count_4", {24'b0, err_count}, 32'd4);
    stub_mode = 1'b0;

    // Backpressure: fill FIFO behind a pending response
    rsp_ready = 1'b0;
    rd0 = n_rd;
    idx = 0; full_seen = 1'b0; acc_at_full = -1;
    for (int k = 0; k < 20 && !full_seen; k++) begin
      @(negedge clock);
      if (!cmd_ready) begin
        full_seen = 1'b1; acc_at_full = idx; cmd_valid = 1'b0;
      end else begin
        cmd_valid = 1'b1; cmd_write = bp_wr[idx]; cmd_addr = bp_addr[idx];
        cmd_wdata = bp_wd[idx]; idx++;
      end
    end
    check_val("bp_accepts_at_full", acc_at_full, 32'd5);
    repeat (6) @(negedge clock);
    check_val("bp_still_full", {31'b0, cmd_ready}, 32'd0);
    check_val("bp_one_strobe", n_rd - rd0, 32'd1);
    check_val("bp_held_rdata", rsp_rdata, 32'h3);

    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = bp_wr[5]; cmd_addr = bp_addr[5]; cmd_wdata = bp_wd[5];
    got = 0; acc_next = 1'b0; any_err = 1'b0;
    for (int k = 0; k < 200 && got < 6; k++) begin
      if (cmd_valid && acc_next) cmd_valid = 1'b0;
      acc_next = cmd_valid && cmd_ready;
      if (rsp_valid) begin
        check_val($sformatf("bp_rdata%0d", got), rsp_rdata, bp_exp[got]);
        any_err |= rsp_error;
        got++;
      end
      @(negedge clock);
    end
    check_val("bp_resp_count", got, 32'd6);
    check_val("bp_no_errors", {31'b0, any_err}, 32'd0);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clock);

    // Reset while waiting on the responder
    stub_mode = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h04;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clock);
    check_val("pre_rst_busy", {31'b0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_val("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_val("arst_busy", {31'b0, busy}, 32'd0);
    check_val("arst_err_count", {24'b0, err_count}, 32'd0);
    check_val("arst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check_val("arst_addr", {26'b0, reg_addr}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1; stub_mode = 1'b0;
    saw_rsp = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clock);
      saw_rsp |= rsp_valid;
    end
    check_val("arst_no_response", {31'b0, saw_rsp}, 32'd0);
    check_val("arst_idle_busy", {31'b0, busy}, 32'd0);

    do_cmd(1'b0, 6'h04, 32'h0, rd, er, tm, lat);
    check_val("post_rst_rd04", rd, 32'h8);
    check_val("post_rst_latency", lat, 32'd4);
    check_val("never_both_strobes", n_both, 32'd0);

    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "bench timeout");
  end

endmodule
